// File: rtl/mux2to1_rr_arbiter.sv
// Round-robin 2:1 arbiter that shares one registered N-bit output between two
// valid/ready requesters, with a burst cap on consecutive beats per grant.
//
// state   | meaning
// IDLE    | no owner; waiting for a requester to go valid
// GRANT_A | A owns the output register and may push beats
// GRANT_B | B owns the output register and may push beats
module mux2to1_rr_arbiter #(
  parameter int N         = 32,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] A,
  input  logic         A_valid,
  output logic         A_ready,
  input  logic [N-1:0] B,
  input  logic         B_valid,
  output logic         B_ready,
  output logic [N-1:0] Y,
  output logic         Y_valid,
  input  logic         Y_ready,
  output logic         S
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   y_q, y_d;
  logic           y_valid_q, y_valid_d;
  logic           s_q, s_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;   // 1 = B was granted most recently

  logic           slot;
  logic           own_valid;
  logic           oth_valid;
  logic [N-1:0]   own_data;
  logic           accept;
  logic           cap;
  logic [CW-1:0]  cnt_inc;
  logic           do_grant;
  logic           grant_b;

  assign slot    = !y_valid_q || Y_ready;
  assign A_ready = (state_q == GRANT_A) && slot;
  assign B_ready = (state_q == GRANT_B) && slot;

  assign Y       = y_q;
  assign Y_valid = y_valid_q;
  assign S       = s_q;

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    do_grant  = 1'b0;
    grant_b   = 1'b0;

    own_valid = (state_q == GRANT_B) ? B_valid : A_valid;
    oth_valid = (state_q == GRANT_B) ? A_valid : B_valid;
    own_data  = (state_q == GRANT_B) ? B : A;
    accept    = (A_valid && A_ready) || (B_valid && B_ready);
    cnt_inc   = cnt_q + 1'b1;
    cap       = accept && (cnt_inc == CW'(MAX_BURST));

    // A stalled output register freezes everything, including the FSM.
    if (slot) begin
      if (accept) begin
        y_d       = own_data;
        y_valid_d = 1'b1;
        s_d       = (state_q == GRANT_B);
        cnt_d     = cnt_inc;
      end else begin
        y_valid_d = 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (A_valid && B_valid) begin
            do_grant = 1'b1;
            grant_b  = !last_q;
          end else if (A_valid || B_valid) begin
            do_grant = 1'b1;
            grant_b  = B_valid;
          end
        end
        GRANT_A, GRANT_B: begin
          if (cap || !own_valid) begin
            if (oth_valid) begin
              do_grant = 1'b1;
              grant_b  = (state_q == GRANT_A);
            end else if (cap && own_valid) begin
              do_grant = 1'b1;
              grant_b  = (state_q == GRANT_B);
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (do_grant) begin
        state_d = grant_b ? GRANT_B : GRANT_A;
        cnt_d   = '0;
        last_d  = grant_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      s_q       <= 1'b0;
      cnt_q     <= '0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_mux2to1_rr_arbiter.sv
// Bench for mux2to1_rr_arbiter: behavioural ownership/output model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_mux2to1_rr_arbiter;

  localparam int N  = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  A = '0;
  logic [N-1:0]  B = '0;
  logic          A_valid = 1'b0;
  logic          B_valid = 1'b0;
  logic          Y_ready = 1'b1;
  logic          A_ready, B_ready, Y_valid, S;
  logic [N-1:0]  Y;

  mux2to1_rr_arbiter #(.N(N), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .A(A), .A_valid(A_valid), .A_ready(A_ready),
    .B(B), .B_valid(B_valid), .B_ready(B_ready),
    .Y(Y), .Y_valid(Y_valid), .Y_ready(Y_ready),
    .S(S)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: owner -1 = nobody, 0 = A, 1 = B; beats = beats taken in this grant.
  typedef struct {
    int          owner;
    int          beats;
    int          last;
    logic [31:0] y;
    bit          yv;
    bit          s;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t m_reset();
    mstate_t r;
    r.owner = -1; r.beats = 0; r.last = 1; r.y = '0; r.yv = 0; r.s = 0;
    return r;
  endfunction

  function automatic mstate_t m_enter(input mstate_t c, input int who);
    mstate_t r = c;
    r.owner = who; r.beats = 0; r.last = who;
    return r;
  endfunction

  function automatic mstate_t m_step(input mstate_t c, input bit [1:0] v,
                                     input logic [31:0] d0, input logic [31:0] d1,
                                     input bit yr);
    mstate_t n = c;
    bit acc = 0;
    bit cap;
    int other;
    if (c.yv && !yr) return c;
    if (c.owner >= 0) acc = v[c.owner];
    if (acc) begin
      n.y = (c.owner == 1) ? d1 : d0;
      n.yv = 1; n.s = (c.owner == 1); n.beats = c.beats + 1;
    end else begin
      n.yv = 0;
    end
    if (c.owner < 0) begin
      if (v == 2'b11) n = m_enter(n, 1 - c.last);
      else if (v == 2'b01) n = m_enter(n, 0);
      else if (v == 2'b10) n = m_enter(n, 1);
    end else begin
      cap = acc && (n.beats == MB);
      if (cap || !v[c.owner]) begin
        other = 1 - c.owner;
        if (v[other]) n = m_enter(n, other);
        else if (cap && v[c.owner]) n = m_enter(n, c.owner);
        else n.owner = -1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= m_reset();
    else        m <= m_step(m, {B_valid, A_valid}, A, B, Y_ready);
  end

  logic m_slot;
  always @(negedge clk) begin
    m_slot = !m.yv || Y_ready;
    check("model_Y", Y, m.y);
    check("model_Y_valid", Y_valid, m.yv);
    check("model_S", S, m.s);
    check("model_A_ready", A_ready, (m.owner == 0) && m_slot);
    check("model_B_ready", B_ready, (m.owner == 1) && m_slot);
  end

  logic a_acc, b_acc;
  task automatic tick();
    @(negedge clk);
    a_acc = A_valid && A_ready;
    b_acc = B_valid && B_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_Y_valid", Y_valid, 0);
    check("rst_A_ready", A_ready, 0);
    check("rst_B_ready", B_ready, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, gaps, ea, eb, own;
    bit started;
    logic [31:0] exp;

    // 1: reset with A valid, first beat two edges after release
    rst_n = 1'b0; A_valid = 1'b1; A = 32'h1234_5678; Y_ready = 1'b1;
    #2;
    check("t1_rst_Y", Y, 0);
    check("t1_rst_Y_valid", Y_valid, 0);
    check("t1_rst_A_ready", A_ready, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #3;
    check("t1_edge1_Y_valid", Y_valid, 0);
    check("t1_edge1_A_ready", A_ready, 1);
    @(posedge clk); #3;
    check("t1_edge2_Y", Y, 32'h1234_5678);
    check("t1_edge2_Y_valid", Y_valid, 1);
    check("t1_edge2_S", S, 0);
    A_valid = 1'b0;

    // 2+3: both valid, 4/4 alternation, a 3-cycle stall mid-stream
    A_valid = 1'b1; B_valid = 1'b1;
    A = 32'hA000_0000; B = 32'hB000_0000;
    apply_reset();
    got = 0; gaps = 0; ea = 0; eb = 0; started = 0;
    for (int c = 0; c < 60 && got < 24; c++) begin
      tick();
      if (a_acc) A = A + 1;
      if (b_acc) B = B + 1;
      Y_ready = !(c >= 12 && c < 15);
      #2;
      if (!Y_ready) begin
        check("t3_stall_A_ready", A_ready, 0);
        check("t3_stall_B_ready", B_ready, 0);
      end
      if (Y_valid) begin
        started = 1;
        own = (got / 4) % 2;
        exp = (own == 1) ? 32'hB000_0000 + eb : 32'hA000_0000 + ea;
        check("t2_S", S, own);
        check("t2_Y", Y, exp);
        if (Y_ready) begin
          got++;
          if (own == 1) eb++; else ea++;
        end
      end else if (started) begin
        gaps++;
      end
    end
    check("t2_beats", got, 24);
    check("t2_bubbles", gaps, 0);
    Y_ready = 1'b1;

    // 4: single A beat, back to idle, then a B beat
    A_valid = 1'b0; B_valid = 1'b0;
    apply_reset();
    A = 32'hAAAA_AAAA; A_valid = 1'b1;
    tick(); #2;
    check("t4_A_ready", A_ready, 1);
    tick(); A_valid = 1'b0; #2;
    check("t4_Y", Y, 32'hAAAA_AAAA);
    check("t4_Y_valid", Y_valid, 1);
    check("t4_S", S, 0);
    tick(); #2;
    check("t4_idle_Y_valid", Y_valid, 0);
    check("t4_idle_A_ready", A_ready, 0);
    check("t4_idle_Y_hold", Y, 32'hAAAA_AAAA);
    B = 32'h5555_5555; B_valid = 1'b1;
    tick(); tick(); B_valid = 1'b0; #2;
    check("t4_B_S", S, 1);
    check("t4_B_Y", Y, 32'h5555_5555);
    check("t4_B_Y_valid", Y_valid, 1);

    // 5: A alone, continuous 1,2,3,... with re-grants and no gap
    A = 32'd1; A_valid = 1'b1; B_valid = 1'b0;
    apply_reset();
    got = 0; gaps = 0; started = 0;
    for (int c = 0; c < 40 && got < 13; c++) begin
      tick();
      if (a_acc) A = A + 1;
      #2;
      if (Y_valid) begin
        started = 1;
        check("t5_Y", Y, got + 1);
        check("t5_S", S, 0);
        got++;
      end else if (started) begin
        gaps++;
      end
    end
    check("t5_beats", got, 13);
    check("t5_gaps", gaps, 0);

    // 6: reset in the middle of that burst, then a tie goes to A
    B = 32'hBBBB_0000; B_valid = 1'b1;
    exp = A;
    apply_reset();
    tick(); tick(); #2;
    check("t6_S", S, 0);
    check("t6_Y", Y, exp);
    check("t6_Y_valid", Y_valid, 1);

    // 7: randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) apply_reset();
      tick();
      if (c % 400 < 100) begin
        A_valid = 1'b1; B_valid = 1'b1;
      end else begin
        A_valid = ($urandom_range(0, 3) != 0);
        B_valid = ($urandom_range(0, 2) == 0);
      end
      A = $urandom;
      B = $urandom;
      Y_ready = ($urandom_range(0, 3) != 0);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
